// File: rtl/matvec_seq_engine_if.sv
// matvec_seq_engine_if
//   Bundles the start/result handshake and the weight-write port of
//   matvec_seq_engine.
//
//   Handshake: the consumer side drives `mult` to request an operation.
//   The engine raises `valid` when `vec_out`/`sat` hold a complete result
//   and keeps all three stable until it samples `ack` high on a rising
//   edge. `valid` then drops on that same edge. `mult` is only honoured
//   while the engine is idle. `ack` is only honoured while a result is
//   pending.
//
//   Signals (direction seen from the engine, i.e. the slave modport):
//     mult     in   start request
//     vec_in   in   packed input vector, element k at [IN_W*k +: IN_W]
//     ack      in   consumer accepts the pending result
//     valid    out  result available
//     vec_out  out  packed result, element k at [OUT_W*k +: OUT_W]
//     sat      out  at least one element of the result was clamped
//     busy     out  operation in progress or result pending
//     w_we     in   weight write enable
//     w_row    in   weight row index
//     w_col    in   weight column index
//     w_data   in   weight value
interface matvec_seq_engine_if #(
    parameter int N     = 9,
    parameter int IN_W  = 7,
    parameter int OUT_W = 8
);
    localparam int IDX_W = $clog2(N);

    logic                 mult;
    logic [N*IN_W-1:0]    vec_in;
    logic                 ack;
    logic                 valid;
    logic [N*OUT_W-1:0]   vec_out;
    logic                 sat;
    logic                 busy;
    logic                 w_we;
    logic [IDX_W-1:0]     w_row;
    logic [IDX_W-1:0]     w_col;
    logic [IN_W-1:0]      w_data;

    modport master (
        output mult, vec_in, ack, w_we, w_row, w_col, w_data,
        input  valid, vec_out, sat, busy
    );

    modport slave (
        input  mult, vec_in, ack, w_we, w_row, w_col, w_data,
        output valid, vec_out, sat, busy
    );
endinterface

// File: rtl/matvec_seq_engine.sv
// matvec_seq_engine
//   Sequential N x N unsigned matrix-vector multiplier. A run-time writable
//   weight matrix (identity after reset) is multiplied by a latched input
//   vector, one row per clock. Each row sum is clamped to OUT_W bits and a
//   sticky saturation flag records whether any row was clamped. The result
//   is held on a valid/ack handshake (see matvec_seq_engine_if).
//
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous, active-high
//     bus        slave modport of matvec_seq_engine_if
//     fsm_state  out  current FSM state (IDLE=0, COMPUTE=1, SEND=2)
module matvec_seq_engine #(
    parameter int N     = 9,
    parameter int IN_W  = 7,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    matvec_seq_engine_if.slave       bus,
    output logic [1:0]               fsm_state
);
    localparam int IDX_W = $clog2(N);
    // Worst-case sum is N * (2^IN_W-1)^2, which fits in 2*IN_W + clog2(N).
    localparam int ACC_W = 2*IN_W + IDX_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;

    localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

    logic [1:0]            state_q;
    logic [IDX_W-1:0]      row;
    logic [N*IN_W-1:0]     vec_q;
    logic [N*OUT_W-1:0]    out_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  sat_q;
    logic [IN_W-1:0]       w_mem [N][N];

    logic [ACC_W-1:0]      acc;
    logic                  over;
    logic [OUT_W-1:0]      clamped;
    logic                  w_addr_ok;

    // Indices are compared one bit wider so that N being a power of two
    // does not wrap the bound to zero.
    assign w_addr_ok = ({1'b0, bus.w_row} < (IDX_W+1)'(N)) &&
                       ({1'b0, bus.w_col} < (IDX_W+1)'(N));

    // Dot product of the current row with the latched vector, full width.
    always_comb begin
        acc = '0;
        for (int c = 0; c < N; c++) begin
            acc = acc + (ACC_W'(w_mem[row][c]) * ACC_W'(vec_q[IN_W*c +: IN_W]));
        end
    end

    assign over    = acc > ACC_W'(OUT_MAX);
    assign clamped = over ? OUT_MAX : acc[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row     <= '0;
            vec_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            sat_q   <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_mem[r][c] <= (r == c) ? IN_W'(1) : '0;
                end
            end
        end else begin
            // The matrix is frozen outside IDLE. A write in the same cycle
            // as mult lands before the first COMPUTE cycle reads it.
            if (state_q == IDLE && bus.w_we && w_addr_ok) begin
                w_mem[bus.w_row][bus.w_col] <= bus.w_data;
            end

            case (state_q)
                IDLE: begin
                    if (bus.mult) begin
                        vec_q   <= bus.vec_in;
                        sat_q   <= 1'b0;
                        row     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    out_q[OUT_W*int'(row) +: OUT_W] <= clamped;
                    if (over) begin
                        sat_q <= 1'b1;
                    end
                    if (row == IDX_W'(N-1)) begin
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                SEND: begin
                    // vec_out and sat are deliberately left as-is on ack.
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid   = valid_q;
    assign bus.vec_out = out_q;
    assign bus.sat     = sat_q;
    assign bus.busy    = busy_q;
    assign fsm_state   = state_q;
endmodule

// File: tb/tb_matvec_seq_engine.sv
// tb_matvec_seq_engine
//   Directed bench for matvec_seq_engine with the default 9x9, 7-bit in,
//   8-bit out configuration. A table of vectors with hand-computed results
//   drives the main function; hand-written sequences cover the handshake,
//   ignored inputs, same-cycle write/start and mid-operation reset.
module tb_matvec_seq_engine;
    localparam int N     = 9;
    localparam int IN_W  = 7;
    localparam int OUT_W = 8;
    localparam int IDX_W = $clog2(N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_SEND    = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] fsm_state;

    matvec_seq_engine_if #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    matvec_seq_engine #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N*OUT_W-1:0] exp_q[$];

    typedef struct {
        bit                  load_ones;
        logic [N*IN_W-1:0]   vec;
        logic [N*OUT_W-1:0]  exp_out;
        logic                exp_sat;
    } vec_rec_t;

    vec_rec_t tbl[5];

    // ---------------- helpers ----------------
    function automatic logic [N*IN_W-1:0] fill_in(input int v);
        logic [N*IN_W-1:0] r;
        for (int k = 0; k < N; k++) r[IN_W*k +: IN_W] = IN_W'(v);
        return r;
    endfunction

    function automatic logic [N*OUT_W-1:0] fill_out(input int v);
        logic [N*OUT_W-1:0] r;
        for (int k = 0; k < N; k++) r[OUT_W*k +: OUT_W] = OUT_W'(v);
        return r;
    endfunction

    function automatic logic [N*IN_W-1:0] ramp_in();
        logic [N*IN_W-1:0] r;
        for (int k = 0; k < N; k++) r[IN_W*k +: IN_W] = IN_W'(k);
        return r;
    endfunction

    function automatic logic [N*OUT_W-1:0] ramp_out();
        logic [N*OUT_W-1:0] r;
        for (int k = 0; k < N; k++) r[OUT_W*k +: OUT_W] = OUT_W'(k);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_w(input int r, input int c, input int d);
        @(negedge clk);
        bus.w_we   = 1'b1;
        bus.w_row  = IDX_W'(r);
        bus.w_col  = IDX_W'(c);
        bus.w_data = IN_W'(d);
        @(posedge clk);
        #1;
        bus.w_we = 1'b0;
    endtask

    task automatic load_ones();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                write_w(r, c, 1);
    endtask

    // Returns after edge E0 (the edge that samples mult).
    task automatic start_op(input logic [N*IN_W-1:0] v);
        @(negedge clk);
        bus.vec_in = v;
        bus.mult   = 1'b1;
        @(posedge clk);
        #1;
        bus.mult = 1'b0;
    endtask

    // Counts rising edges until valid is seen; bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.valid) break;
        end
    endtask

    task automatic ack_op();
        @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
    endtask

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        logic [N*OUT_W-1:0] exp_v;
        logic [N*OUT_W-1:0] held;

        bus.mult   = 1'b0;
        bus.vec_in = '0;
        bus.ack    = 1'b0;
        bus.w_we   = 1'b0;
        bus.w_row  = '0;
        bus.w_col  = '0;
        bus.w_data = '0;

        tbl[0] = '{1'b0, ramp_in(),   ramp_out(),    1'b0}; // identity
        tbl[1] = '{1'b1, fill_in(10), fill_out(90),  1'b0}; // all ones, 9*10
        tbl[2] = '{1'b0, fill_in(30), fill_out(255), 1'b1}; // 270 clamps
        tbl[3] = '{1'b0, fill_in(1),  fill_out(9),   1'b0}; // sat cleared
        tbl[4] = '{1'b0, ramp_in(),   fill_out(36),  1'b0}; // 0+1+..+8

        do_reset();
        check("rst_valid", 128'(bus.valid), 128'(0));
        check("rst_busy",  128'(bus.busy),  128'(0));
        check("rst_sat",   128'(bus.sat),   128'(0));
        check("rst_out",   128'(bus.vec_out), 128'(0));
        check("rst_state", 128'(fsm_state), 128'(S_IDLE));

        // Table-driven runs.
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].load_ones) load_ones();
            exp_q.push_back(tbl[i].exp_out);
            start_op(tbl[i].vec);
            check($sformatf("t%0d_busy_e0", i), 128'(bus.busy), 128'(1));
            check($sformatf("t%0d_state_e0", i), 128'(fsm_state), 128'(S_COMPUTE));
            wait_valid(lat);
            check($sformatf("t%0d_latency", i), 128'(lat), 128'(N));
            check($sformatf("t%0d_out", i), 128'(bus.vec_out), 128'(exp_q.pop_front()));
            check($sformatf("t%0d_sat", i), 128'(bus.sat), 128'(tbl[i].exp_sat));
            check($sformatf("t%0d_busy_send", i), 128'(bus.busy), 128'(1));
            ack_op();
            check($sformatf("t%0d_valid_ack", i), 128'(bus.valid), 128'(0));
            check($sformatf("t%0d_busy_ack", i), 128'(bus.busy), 128'(0));
            check($sformatf("t%0d_state_ack", i), 128'(fsm_state), 128'(S_IDLE));
        end

        // Handshake hold: weights are all ones, vec all 2 -> 18.
        start_op(fill_in(2));
        wait_valid(lat);
        held = fill_out(18);
        check("hold_first", 128'(bus.vec_out), 128'(held));
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_valid_%0d", k), 128'(bus.valid), 128'(1));
            check($sformatf("hold_out_%0d", k), 128'(bus.vec_out), 128'(held));
        end
        ack_op();
        check("hold_valid_ack", 128'(bus.valid), 128'(0));
        check("hold_state_ack", 128'(fsm_state), 128'(S_IDLE));
        check("hold_out_kept", 128'(bus.vec_out), 128'(held));
        ack_op(); // stray ack in IDLE
        check("idle_ack_valid", 128'(bus.valid), 128'(0));
        check("idle_ack_busy", 128'(bus.busy), 128'(0));
        check("idle_ack_out", 128'(bus.vec_out), 128'(held));

        // mult together with ack in SEND must not start a new run.
        start_op(fill_in(1));
        wait_valid(lat);
        @(negedge clk);
        bus.mult = 1'b1;
        bus.ack  = 1'b1;
        @(posedge clk);
        #1;
        bus.mult = 1'b0;
        bus.ack  = 1'b0;
        check("multack_valid", 128'(bus.valid), 128'(0));
        check("multack_state", 128'(fsm_state), 128'(S_IDLE));
        @(posedge clk);
        #1;
        check("multack_busy_later", 128'(bus.busy), 128'(0));
        check("multack_state_later", 128'(fsm_state), 128'(S_IDLE));

        // Write and mult during COMPUTE are ignored.
        start_op(fill_in(2));
        @(negedge clk);
        bus.w_we   = 1'b1;
        bus.w_row  = '0;
        bus.w_col  = '0;
        bus.w_data = IN_W'(5);
        bus.mult   = 1'b1;
        bus.vec_in = fill_in(9);
        repeat (3) @(posedge clk);
        #1;
        bus.w_we = 1'b0;
        bus.mult = 1'b0;
        wait_valid(lat);
        check("busy_ign_arrived", 128'(lat < 100), 128'(1));
        check("busy_ign_out", 128'(bus.vec_out), 128'(fill_out(18)));
        ack_op();
        start_op(fill_in(1));
        wait_valid(lat);
        check("busy_ign_w00", 128'(bus.vec_out), 128'(fill_out(9)));
        ack_op();

        // Write in the same IDLE cycle as mult is used by that run.
        @(negedge clk);
        bus.w_we   = 1'b1;
        bus.w_row  = '0;
        bus.w_col  = '0;
        bus.w_data = IN_W'(3);
        bus.mult   = 1'b1;
        bus.vec_in = fill_in(1);
        @(posedge clk);
        #1;
        bus.w_we = 1'b0;
        bus.mult = 1'b0;
        wait_valid(lat);
        exp_v = fill_out(9);
        exp_v[OUT_W-1:0] = OUT_W'(11);
        check("same_cycle_lat", 128'(lat), 128'(N));
        check("same_cycle_out", 128'(bus.vec_out), 128'(exp_v));
        ack_op();
        write_w(0, 0, 1);

        // Out-of-range writes are dropped.
        write_w(9, 0, 5);
        write_w(0, 9, 5);
        write_w(15, 15, 5);
        start_op(fill_in(1));
        wait_valid(lat);
        check("oob_out", 128'(bus.vec_out), 128'(fill_out(9)));
        ack_op();

        // Reset mid-operation at row 4, then identity must be back.
        start_op(fill_in(5));
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_valid", 128'(bus.valid), 128'(0));
        check("midrst_busy",  128'(bus.busy),  128'(0));
        check("midrst_out",   128'(bus.vec_out), 128'(0));
        check("midrst_state", 128'(fsm_state), 128'(S_IDLE));
        start_op(fill_in(3));
        wait_valid(lat);
        check("midrst_lat", 128'(lat), 128'(N));
        check("midrst_identity", 128'(bus.vec_out), 128'(fill_out(3)));
        check("midrst_sat", 128'(bus.sat), 128'(0));
        ack_op();

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matvec_seq_engine.md
Name: matvec_seq_engine

Overview:
- Parametrised successor to the team's 9x9 matrix-vector multiply block.
- Holds an N x N unsigned weight matrix that can be written at run time; reset loads the identity matrix.
- Accepts a packed N-element input vector and computes out[r] = sum over c of W[r][c]*vec[c], one row per clock.
- Each result is clamped to OUT_W bits with a saturation flag, then held for the downstream consumer on a valid/ack handshake.

Parameters:
- N, 9, vector length and matrix dimension (N >= 2).
- IN_W, 7, width of each input element and each weight (unsigned).
- OUT_W, 8, width of each output element (unsigned, saturating).
- Derived localparam ACC_W = 2*IN_W + clog2(N): accumulator width, never overflows.
- Derived localparam IDX_W = clog2(N): width of the row/column indices.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- mult  in  1  start request, sampled only in IDLE.
- vec_in  in  N*IN_W  packed input; element k is at bits [IN_W*k +: IN_W].
- ack  in  1  consumer accepts result, sampled only in SEND.
- valid  out  1  result available on vec_out.
- vec_out  out  N*OUT_W  packed result; element k is at bits [OUT_W*k +: OUT_W].
- sat  out  1  at least one element of the current result was clamped.
- busy  out  1  high in COMPUTE and SEND.
- w_we  in  1  weight write enable.
- w_row  in  IDX_W  weight row index.
- w_col  in  IDX_W  weight column index.
- w_data  in  IN_W  weight value.

Behaviour:
- Reset values:
  - state = IDLE.
  - valid = 0, busy = 0, sat = 0, vec_out = 0, row counter = 0.
  - Weights: W[r][c] = 1 when r == c, otherwise 0.
  - Reset overrides every other input; asserting it mid-COMPUTE or in SEND aborts the operation and restores all of the above.
- States and transitions:
  - IDLE to COMPUTE: when mult = 1.
    - Latch vec_in into an internal vector register, clear sat, set row = 0, set busy = 1.
  - COMPUTE:
    - Each cycle, compute the ACC_W-bit dot product of row `row` with the latched vector.
    - Write min(acc, 2^OUT_W - 1) into out[row].
    - If acc > 2^OUT_W - 1, set sat = 1 (sticky for this result).
    - If row == N-1, go to SEND and set valid = 1 on the same edge; otherwise increment row.
  - SEND:
    - valid is held high; vec_out and sat stay stable until ack.
    - On ack = 1: valid = 0, busy = 0, return to IDLE.
    - vec_out and sat keep their last values; they are not cleared.
- Latency: mult is sampled at edge E0; rows 0..N-1 are written at edges E1..EN; valid is high after edge EN. That is N cycles, 9 by default.
- Ignored inputs:
  - mult outside IDLE, including mult together with ack in SEND. A new start requires mult in a later IDLE cycle.
  - ack outside SEND.
  - vec_in changes after E0; computation uses only the latched copy.
- Weight writes:
  - Accepted only in IDLE with w_we = 1; W[w_row][w_col] = w_data at that edge.
  - Dropped if w_row >= N or w_col >= N.
  - Dropped in COMPUTE and SEND; the matrix is frozen during an operation.
  - If w_we and mult are both high in the same IDLE cycle, the write takes effect and the started operation uses the updated matrix.
- Arithmetic: all values unsigned. Products and sums are held at ACC_W bits with no intermediate truncation; the clamp is applied only to the final sum.

Test Plan:
- Identity after reset: reset, then mult with vec_in elements = {0,1,2,...,8} -> valid rises exactly 9 cycles after mult edge; vec_out = {0,...,8}; sat = 0; busy high from E0 until ack.
- Loaded weights: write all 81 weights = 1, vec all 10 -> every out = 90, sat = 0.
- Saturation: all weights = 1, vec all 30 -> sums of 270 clamp to 255, sat = 1. A follow-up run with vec all 1 -> out = 9, sat = 0 (sat cleared at start).
- Handshake hold: delay ack 20 cycles -> valid and vec_out stay stable. ack for 1 cycle -> valid = 0 next cycle, state IDLE, vec_out retained. Extra ack in IDLE -> no effect.
- Ignored inputs while busy: in COMPUTE, assert w_we (row 0, col 0, data 5) and mult with a new vec -> result matches the pre-op weights and the originally latched vec; W[0][0] unchanged afterwards. Write with w_row = 9 in IDLE -> dropped.
- Reset mid-op: reset at row 4 -> after reset, valid = 0, busy = 0, vec_out = 0, weights back to identity; a following mult with vec all 3 -> out all 3.
